shared_zero_shuffle_pipe: RTL and testbench
===========================================

Name: shared_zero_shuffle_pipe

Overview:
- Parametrised successor to the fixed 4-bit-plane zero-shift shuffle path. Used when a submatrix has shift factor 0: the QSN is bypassed and the message must still match the QSN pipeline latency.
- Selects, per bit plane, one of NUM_SRC input word sets with a one-hot select. Carries the result through a DEPTH-stage elastic valid/ready pipeline.
- Supports back-pressure, bubble collapse, flush and occupancy reporting; the predecessor had none of these.
- Sits between the CNU/VNU message memories and the layer decoder datapath, in parallel with shared_qsn_top.

Parameters:
- CHECK_PARALLELISM, 255, bits per bit plane (submatrix size).
- QUAN_SIZE, 4, number of bit planes (message quantisation width).
- NUM_SRC, 3, number of selectable input sources; legal range 1..8.
- DEPTH, 2, pipeline stages; legal range 1..8; must equal the QSN latency.
- OCC_W, $clog2(DEPTH+1), width of the occupancy output.

Ports:
- sys_clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discards all in-flight words.
- in_valid  in  1  input word valid.
- in_ready  out  1  pipeline accepts the input word this cycle.
- in_data  in  NUM_SRC*QUAN_SIZE*CHECK_PARALLELISM  source s, plane q at bit offset (s*QUAN_SIZE+q)*CHECK_PARALLELISM.
- in_src_sel  in  QUAN_SIZE*NUM_SRC  one-hot source select for plane q at bits [q*NUM_SRC +: NUM_SRC].
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_data  out  QUAN_SIZE*CHECK_PARALLELISM  plane q at [q*CHECK_PARALLELISM +: CHECK_PARALLELISM].
- sel_err  out  1  the current output word had a non-one-hot select on at least one plane; qualified by out_valid.
- occupancy  out  OCC_W  number of valid stages.

Behaviour:
- Reset: while rst=1, at the clock edge all stage valids, data, error flags and the occupancy count clear to 0. Outputs after reset: out_valid=0, out_data=0, sel_err=0, occupancy=0. in_ready=1 from the first cycle after reset.
- rst has priority over flush. flush has priority over any accept or advance in the same cycle.
- Selection (combinational, ahead of stage 0): plane q = XOR over s of (in_src_sel[q*NUM_SRC+s] ? source s plane q : 0).
  - An all-zero select yields 0.
  - A multi-hot select yields the XOR of the selected sources and sets the word's err bit.
  - err = OR over all planes of (popcount of that plane's select != 1).
- Stage k state: valid[k], data[k], err[k]. Stage DEPTH-1 drives the outputs.
- Advance rule, combinational chain from the output side:
  - adv[DEPTH-1] = valid[DEPTH-1] & out_ready.
  - adv[k] = valid[k] & (!valid[k+1] | adv[k+1]).
- in_ready = !valid[0] | adv[0]. in_ready does not depend on in_valid.
- Stage update at each edge, when not flushing:
  - Stage 0 loads when in_valid & in_ready.
  - Stage k>0 loads from stage k-1 when adv[k-1].
  - A stage that advanced and did not load clears its valid.
  - Data and err registers hold when their stage does not load.
- Bubbles collapse: an empty stage accepts from upstream even when downstream is stalled.
- Latency with out_ready held at 1: exactly DEPTH cycles from input handshake to out_valid. Throughput is 1 word per cycle.
- Full: all DEPTH stages valid and out_ready=0 gives in_ready=0; stage data is held stable. out_valid/out_data must not change while stalled.
- Simultaneous output pop and input push when full: both transfers happen and occupancy is unchanged.
- Flush: all valids clear at the edge, and a same-cycle input handshake is dropped. Next cycle: out_valid=0, occupancy=0. Data registers keep their contents, which are don't-care.
- occupancy is a registered count: +1 on input handshake, -1 on output handshake, net 0 when both occur; set to 0 on flush or rst. It never exceeds DEPTH.

Decomposition:
- Shared package ldpc_perm_pkg holds:
  - localparams for QUAN_SIZE and CHECK_PARALLELISM defaults;
  - a function onehot_check(sel) returning 1 when exactly one bit is set;
  - the plane-offset helper function.
- One sub-module: perm_src_select. It is the combinational per-plane one-hot XOR mux with error output, generalising scalable_mux_3_to_1 to NUM_SRC. The top level instantiates it once for each of the QUAN_SIZE planes.

Test Plan (CHECK_PARALLELISM=8, QUAN_SIZE=4, NUM_SRC=3, DEPTH=2):
- Latency check: out_ready=1; one word with source 1 planes = 8'hA5, 8'h3C, 8'h0F, 8'hF0 and select 3'b010 on every plane. Required: out_valid rises exactly 2 cycles later, out_data={F0,0F,3C,A5}, sel_err=0.
- Streaming: 10 back-to-back words with incrementing payload. Then out_ready=0 for 3 cycles. Required: in_ready drops once occupancy=2, no word is lost or duplicated, order is preserved, out_data is stable while stalled.
- Bubble collapse: push word, idle 1 cycle, push word, with out_ready=0. Required: occupancy reaches 2 and in_ready=0. Releasing out_ready delivers both words on consecutive cycles.
- Multi-hot select: plane 0 select 3'b101 with source0=8'h11, source2=8'h22. Required: plane 0 output = 8'h33 and sel_err=1. An all-zero select on plane 0 gives 8'h00 and sel_err=1.
- Flush under stall: full pipe plus in_valid=1 and flush=1 in the same cycle. Required: next cycle out_valid=0, occupancy=0, in_ready=1, and the dropped word never appears at the output.
- Reset mid-stream: rst=1 for 1 cycle while 2 words are in flight. Required: next cycle out_valid=0, out_data=0, sel_err=0, occupancy=0, and no stale word emerges afterwards.

Source files
------------

// File: rtl/shared_zero_shuffle_pipe_pkg.sv
// Shared definitions for the zero-shift permutation path: default sizes and
// helpers for select checking and bit-plane addressing.
package ldpc_perm_pkg;

    localparam int QUAN_SIZE_DEF         = 4;
    localparam int CHECK_PARALLELISM_DEF = 255;

    // True when exactly one bit of a (zero-extended) source select is set.
    function automatic logic onehot_check(input logic [7:0] sel);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n += 32'(sel[i]);
        end
        return (n == 32'd1);
    endfunction

    // Bit offset of source src, plane plane within the packed input bus.
    function automatic int plane_offset(input int src, input int plane,
                                        input int quan, input int cp);
        return (src * quan + plane) * cp;
    endfunction

endpackage

// File: rtl/shared_zero_shuffle_pipe_if.sv
// Upstream/downstream handshake bundle of the zero-shift shuffle pipe.
// master = the side that feeds words in and drains them; slave = the pipe.
interface shared_zero_shuffle_pipe_if #(
    parameter int CHECK_PARALLELISM = 255,
    parameter int QUAN_SIZE         = 4,
    parameter int NUM_SRC           = 3,
    parameter int DEPTH             = 2,
    parameter int OCC_W             = $clog2(DEPTH + 1)
);
    logic                                          flush;
    logic                                          in_valid;
    logic                                          in_ready;
    logic [NUM_SRC*QUAN_SIZE*CHECK_PARALLELISM-1:0] in_data;
    logic [QUAN_SIZE*NUM_SRC-1:0]                  in_src_sel;
    logic                                          out_valid;
    logic                                          out_ready;
    logic [QUAN_SIZE*CHECK_PARALLELISM-1:0]        out_data;
    logic                                          sel_err;
    logic [OCC_W-1:0]                              occupancy;

    modport master (
        output flush, in_valid, in_data, in_src_sel, out_ready,
        input  in_ready, out_valid, out_data, sel_err, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, in_src_sel, out_ready,
        output in_ready, out_valid, out_data, sel_err, occupancy
    );
endinterface

// File: rtl/shared_zero_shuffle_pipe_src_select.sv
// One bit plane of the zero-shift path: XOR of every selected source plane,
// flagging any select that is not exactly one-hot.
module perm_src_select
    import ldpc_perm_pkg::*;
#(
    parameter int CHECK_PARALLELISM = 255,
    parameter int NUM_SRC           = 3
) (
    input  logic [NUM_SRC*CHECK_PARALLELISM-1:0] src_planes,
    input  logic [NUM_SRC-1:0]                   sel,
    output logic [CHECK_PARALLELISM-1:0]         plane,
    output logic                                 err
);

    logic [7:0] sel_ext;

    always_comb begin
        plane = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (sel[s]) begin
                plane = plane ^ src_planes[s*CHECK_PARALLELISM +: CHECK_PARALLELISM];
            end
        end
        sel_ext                = '0;
        sel_ext[NUM_SRC-1:0]   = sel;
        err                    = !onehot_check(sel_ext);
    end

endmodule

// File: rtl/shared_zero_shuffle_pipe.sv
// Zero-shift bypass of the QSN: per-plane source select followed by a DEPTH-stage
// elastic pipeline so the message arrives with the same latency as the QSN path.
module shared_zero_shuffle_pipe
    import ldpc_perm_pkg::*;
#(
    parameter int CHECK_PARALLELISM = CHECK_PARALLELISM_DEF,
    parameter int QUAN_SIZE         = QUAN_SIZE_DEF,
    parameter int NUM_SRC           = 3,
    parameter int DEPTH             = 2,
    parameter int OCC_W             = $clog2(DEPTH + 1)
) (
    input logic                       sys_clk,
    input logic                       rst,
    shared_zero_shuffle_pipe_if.slave bus
);

    localparam int CP = CHECK_PARALLELISM;
    localparam int DW = QUAN_SIZE * CP;

    logic [DW-1:0]        sel_word;
    logic [QUAN_SIZE-1:0] plane_err;
    logic                 sel_word_err;

    for (genvar q = 0; q < QUAN_SIZE; q++) begin : g_plane
        logic [NUM_SRC*CP-1:0] src_planes;
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            assign src_planes[s*CP +: CP] = bus.in_data[plane_offset(s, q, QUAN_SIZE, CP) +: CP];
        end
        perm_src_select #(
            .CHECK_PARALLELISM (CP),
            .NUM_SRC           (NUM_SRC)
        ) u_src_select (
            .src_planes (src_planes),
            .sel        (bus.in_src_sel[q*NUM_SRC +: NUM_SRC]),
            .plane      (sel_word[q*CP +: CP]),
            .err        (plane_err[q])
        );
    end

    assign sel_word_err = |plane_err;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] err_q;
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] stage_err_in;
    logic [DW-1:0]    stage_data_in [DEPTH];
    logic             chain_ok;
    logic             in_ready_c;
    logic             push;
    logic             pop;
    logic [OCC_W-1:0] occ_q;

    // Walk from the output back: a stage moves if the one after it is empty or moving.
    always_comb begin
        adv      = '0;
        chain_ok = bus.out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv[k]   = valid_q[k] & chain_ok;
            chain_ok = !valid_q[k] | adv[k];
        end
        in_ready_c = chain_ok;
    end

    assign push = bus.in_valid & in_ready_c;
    assign pop  = adv[DEPTH-1];

    always_comb begin
        load[0]          = push;
        stage_data_in[0] = sel_word;
        stage_err_in[0]  = sel_word_err;
        for (int k = 1; k < DEPTH; k++) begin
            load[k]          = adv[k-1];
            stage_data_in[k] = data_q[k-1];
            stage_err_in[k]  = err_q[k-1];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            valid_q <= '0;
            err_q   <= '0;
            occ_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else if (bus.flush) begin
            // Data is left as-is; it is unobservable once the valids drop.
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (load[k]) begin
                    valid_q[k] <= 1'b1;
                    data_q[k]  <= stage_data_in[k];
                    err_q[k]   <= stage_err_in[k];
                end else if (adv[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
            if (push && !pop) begin
                occ_q <= occ_q + OCC_W'(1);
            end else if (pop && !push) begin
                occ_q <= occ_q - OCC_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q[DEPTH-1];
    assign bus.out_data  = data_q[DEPTH-1];
    assign bus.sel_err   = err_q[DEPTH-1];
    assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_shared_zero_shuffle_pipe.sv
// Randomised and directed bench for shared_zero_shuffle_pipe against a queue model
// of an elastic, bubble-collapsing pipeline.
module tb_shared_zero_shuffle_pipe;

    localparam int CP = 8;
    localparam int QS = 4;
    localparam int NS = 3;
    localparam int D  = 2;
    localparam int OW = $clog2(D + 1);
    localparam int DW = QS * CP;
    localparam int IW = NS * QS * CP;
    localparam int SW = QS * NS;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    always #5 sys_clk = ~sys_clk;

    shared_zero_shuffle_pipe_if #(.CHECK_PARALLELISM(CP), .QUAN_SIZE(QS), .NUM_SRC(NS),
                                  .DEPTH(D), .OCC_W(OW)) bus ();

    shared_zero_shuffle_pipe #(.CHECK_PARALLELISM(CP), .QUAN_SIZE(QS), .NUM_SRC(NS),
                               .DEPTH(D), .OCC_W(OW)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        int            age;   // edges since the word was accepted
    } ent_t;

    ent_t mq[$];

    function automatic void ref_word(input logic [IW-1:0] din, input logic [SW-1:0] sel,
                                     output logic [DW-1:0] d, output logic e);
        d = '0;
        e = 1'b0;
        for (int q = 0; q < QS; q++) begin
            for (int s = 0; s < NS; s++) begin
                if (sel[q*NS + s]) d[q*CP +: CP] = d[q*CP +: CP] ^ din[(s*QS + q)*CP +: CP];
            end
            if ($countones(sel[q*NS +: NS]) != 1) e = 1'b1;
        end
    endfunction

    // A word sits at most age-1 stages in, and no further than the words ahead allow.
    function automatic logic [D-1:0] m_slots();
        logic [D-1:0] s;
        s = '0;
        foreach (mq[p]) begin
            int st;
            st = mq[p].age - 1;
            if (D - 1 - p < st) st = D - 1 - p;
            s[st] = 1'b1;
        end
        return s;
    endfunction

    function automatic logic m_out_valid();
        return (mq.size() > 0) && (mq[0].age >= D);
    endfunction

    // Accept if there is a hole anywhere in the run of full stages starting at stage 0.
    function automatic logic m_in_ready();
        logic [D-1:0] s;
        int k;
        s = m_slots();
        k = 0;
        while (k < D && s[k]) k++;
        return (k < D) ? 1'b1 : bus.out_ready;
    endfunction

    always @(posedge sys_clk) begin
        logic          push;
        logic          pop;
        logic [DW-1:0] wd;
        logic          we;
        push = bus.in_valid && m_in_ready();
        pop  = m_out_valid() && bus.out_ready;
        ref_word(bus.in_data, bus.in_src_sel, wd, we);
        if (rst || bus.flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            foreach (mq[i]) mq[i].age++;
            if (push) mq.push_back('{d: wd, e: we, age: 1});
        end
    end

    always @(negedge sys_clk) begin
        if (cmp_en) begin
            chk("in_ready", 64'(bus.in_ready), 64'(m_in_ready()));
            chk("out_valid", 64'(bus.out_valid), 64'(m_out_valid()));
            chk("occupancy", 64'(bus.occupancy), 64'(mq.size()));
            if (m_out_valid()) begin
                chk("out_data", 64'(bus.out_data), 64'(mq[0].d));
                chk("sel_err", 64'(bus.sel_err), 64'(mq[0].e));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_accept(input string name);
        for (int n = 0; n < 100; n++) begin
            @(negedge sys_clk);
            if (bus.in_ready) begin
                tick();
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for in_ready, got 0, expected 1", name);
    endtask

    task automatic drain(input string name);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (mq.size() == 0) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s: drain timeout, occupancy %0d, expected 0", name, mq.size());
    endtask

    function automatic logic [IW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic logic [SW-1:0] rnd_sel();
        logic [SW-1:0] sel;
        for (int q = 0; q < QS; q++) begin
            if ($urandom_range(0, 7) == 0) sel[q*NS +: NS] = 3'($urandom);
            else sel[q*NS +: NS] = 3'b001 << $urandom_range(0, 2);
        end
        return sel;
    endfunction

    initial begin
        logic [IW-1:0] din;
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_src_sel = '0;
        bus.out_ready  = 1'b1;

        // Reset
        rst = 1'b1;
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_sel_err", 64'(bus.sel_err), 64'd0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        tick();

        // Latency: source 1 on every plane
        bus.in_data    = {$urandom, 32'hF00F3CA5, $urandom};
        bus.in_src_sel = {4{3'b010}};
        bus.in_valid   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        @(negedge sys_clk);
        chk("lat_early_valid", 64'(bus.out_valid), 64'd0);
        @(negedge sys_clk);
        chk("lat_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_data", 64'(bus.out_data), 64'h00000000F00F3CA5);
        chk("lat_err", 64'(bus.sel_err), 64'd0);
        drain("lat_drain");

        // Streaming, then stall with a word waiting
        for (int i = 0; i < 10; i++) begin
            bus.in_data = {32'(i*3 + 2), 32'(i*3 + 1), 32'(i*3)};
            for (int q = 0; q < QS; q++) bus.in_src_sel[q*NS +: NS] = 3'b001 << ((i + q) % 3);
            bus.in_valid = 1'b1;
            wait_accept("stream_push");
        end
        bus.in_data   = {32'h0BADF00D, 32'h12345678, 32'hCAFEBABE};
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_occupancy", 64'(bus.occupancy), 64'd2);
            tick();
        end
        bus.out_ready = 1'b1;
        wait_accept("stream_resume");
        drain("stream_drain");

        // Bubble collapse under stall
        bus.out_ready  = 1'b0;
        bus.in_src_sel = {4{3'b001}};
        bus.in_data    = {$urandom, $urandom, 32'h11223344};
        bus.in_valid   = 1'b1;
        wait_accept("bubble_a");
        bus.in_valid = 1'b0;
        tick();
        bus.in_data  = {$urandom, $urandom, 32'h55667788};
        bus.in_valid = 1'b1;
        wait_accept("bubble_b");
        bus.in_valid = 1'b0;
        @(negedge sys_clk);
        chk("bubble_occupancy", 64'(bus.occupancy), 64'd2);
        chk("bubble_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        bus.out_ready = 1'b1;
        @(negedge sys_clk);
        chk("bubble_first", 64'(bus.out_data), 64'h11223344);
        @(negedge sys_clk);
        chk("bubble_second", 64'(bus.out_data), 64'h55667788);
        @(negedge sys_clk);
        chk("bubble_empty", 64'(bus.out_valid), 64'd0);
        tick();

        // Multi-hot and all-zero select on plane 0
        din            = rnd_data();
        din[7:0]       = 8'h11;
        din[71:64]     = 8'h22;
        bus.in_data    = din;
        bus.in_src_sel = {3'b001, 3'b001, 3'b001, 3'b101};
        bus.in_valid   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("multihot_plane0", 64'(bus.out_data[7:0]), 64'h33);
        chk("multihot_err", 64'(bus.sel_err), 64'd1);
        tick();
        bus.in_src_sel = {3'b001, 3'b001, 3'b001, 3'b000};
        bus.in_valid   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("zerosel_plane0", 64'(bus.out_data[7:0]), 64'h00);
        chk("zerosel_err", 64'(bus.sel_err), 64'd1);
        drain("sel_drain");

        // Flush with a full, stalled pipe and a word offered
        bus.out_ready  = 1'b0;
        bus.in_src_sel = {4{3'b001}};
        for (int i = 0; i < 2; i++) begin
            bus.in_data  = rnd_data();
            bus.in_valid = 1'b1;
            wait_accept("flush_fill");
        end
        bus.in_data = {$urandom, $urandom, 32'hDEADBEEF};
        bus.flush   = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge sys_clk);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_occupancy", 64'(bus.occupancy), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        repeat (4) tick();

        // Reset with two words in flight
        for (int i = 0; i < 2; i++) begin
            bus.in_data  = rnd_data();
            bus.in_valid = 1'b1;
            wait_accept("rst_fill");
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge sys_clk);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_out_data", 64'(bus.out_data), 64'd0);
        chk("midrst_sel_err", 64'(bus.sel_err), 64'd0);
        chk("midrst_occupancy", 64'(bus.occupancy), 64'd0);
        repeat (4) tick();

        // Random traffic with occasional flushes
        for (int c = 0; c < 600; c++) begin
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.in_data    = rnd_data();
            bus.in_src_sel = rnd_sel();
            bus.out_ready  = ($urandom_range(0, 2) != 0);
            bus.flush      = ($urandom_range(0, 39) == 0);
            tick();
        end
        bus.flush = 1'b0;
        drain("rand_drain");
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
